tx_crc_append: RTL and testbench

- TX-side Ethernet FCS generator for the 10G MAC, 64-bit datapath; sits between the TX frame assembler and the XGMII encoder.
- Computes CRC-32 over each outgoing frame and appends the 4-byte FCS after the last valid byte, spilling into an extra word when needed.
- Generated FCS is bit-compatible with the RX CRC checker: MSB-first per byte, poly 0x04C11DB7, init 0xFFFFFFFF, FCS = ~crc.
- Frame plus FCS yields residue 0xC704DD7B at the receiver.

---
 rtl/tx_crc_pkg.sv | 30 +++
 rtl/crc32_d64_next.sv | 24 ++
 rtl/tx_crc_append.sv | 231 +++++++++++++++++++++++
 tb/tb_tx_crc_append.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_crc_pkg.sv
// Shared constants, FSM encoding and helpers for the TX FCS generator and the RX checker.
// The CRC is MSB-first per byte and non-reflected; FCS = ~crc, giving the residue below at the receiver.
package tx_crc_pkg;

    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        PAD  = 2'd3
    } state_t;

    // Byte-count field: 000 means a full 8-byte word.
    function automatic logic [3:0] bytes_dec(input logic [2:0] enc);
        return (enc == 3'd0) ? 4'd8 : {1'b0, enc};
    endfunction

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = (c[31] ^ b[i]) ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d64_next.sv
// Combinational next-CRC over the leading 1..8 bytes of a 64-bit word (first byte on [63:56]).
// Byte count uses the 000 = 8 encoding; trailing lanes are ignored.
module crc32_d64_next
    import tx_crc_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [63:0] data_i,
    input  logic [2:0]  bytes_i,
    output logic [31:0] crc_o
);

    logic [3:0] n;

    always_comb begin
        n     = bytes_dec(bytes_i);
        crc_o = crc_i;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n) begin
                crc_o = crc32_byte(crc_o, data_i[63-8*k -: 8]);
            end
        end
    end

endmodule

// File: rtl/tx_crc_append.sv
// Appends the Ethernet FCS after the last valid byte, spilling into a tail word when it does not fit; 1-cycle latency.
// Single output register loads on !out_valid | out_ready; TX_CRC_PAD_EN zero-pads short frames to MIN_FRAME_BYTES.
module tx_crc_append
    import tx_crc_pkg::*;
#(
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    input  logic        in_sof,
    input  logic        in_eof,
    input  logic [2:0]  in_bytes,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    output logic        out_sof,
    output logic        out_eof,
    output logic [2:0]  out_bytes,
    input  logic        out_ready,
    output logic        err_seq
);

    if (MIN_FRAME_BYTES < 1 || MIN_FRAME_BYTES > 65535) begin : g_min_check
        $error("MIN_FRAME_BYTES must fit the 16-bit byte counter");
    end

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [63:0] out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eof_q, out_eof_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        err_q, err_d;
    logic [31:0] spill_q, spill_d;
    logic [2:0]  spill_bytes_q, spill_bytes_d;

    logic        load, accept, take_frame, drop_word;
    logic [3:0]  n_in;
    logic [63:0] in_mask, in_dat_m;
    logic        fin, go_pad, pad_word, fin_small;
    logic [3:0]  fin_n;
    logic [31:0] crc_base, crc_nxt, fcs;
    logic [63:0] crc_dat;
    logic [2:0]  crc_nb;
    logic [95:0] ext;

    assign load       = !out_valid_q || out_ready;
    assign in_ready   = !reset && (state_q == IDLE || state_q == DATA) && load;
    assign accept     = in_valid && in_ready;
    assign take_frame = accept && (in_sof || state_q == DATA);
    assign drop_word  = accept && !in_sof && (state_q == IDLE);
    assign n_in       = bytes_dec(in_bytes);
    assign in_mask    = {64{1'b1}} << {4'd8 - n_in, 3'b000};
    assign in_dat_m   = in_eof ? (in_data & in_mask) : in_data;

`ifdef TX_CRC_PAD_EN
    localparam logic [15:0] MIN_B = 16'(MIN_FRAME_BYTES);

    logic [15:0] cnt_q, cnt_d, cnt_base, rem;

    assign cnt_base = (state_q == PAD) ? cnt_q : (in_sof ? 16'd0 : cnt_q);
    assign rem      = MIN_B - cnt_base;

    // A short frame is finished with zero bytes up to the minimum; beyond one word it goes through PAD.
    always_comb begin
        fin      = 1'b0;
        go_pad   = 1'b0;
        pad_word = 1'b0;
        fin_n    = n_in;
        if (state_q == PAD) begin
            if (load) begin
                if (rem <= 16'd8) begin
                    fin   = 1'b1;
                    fin_n = rem[3:0];
                end else begin
                    pad_word = 1'b1;
                end
            end
        end else if (take_frame && in_eof) begin
            if (({1'b0, cnt_base} + 17'(n_in)) >= {1'b0, MIN_B}) begin
                fin = 1'b1;
            end else if (rem <= 16'd8) begin
                fin   = 1'b1;
                fin_n = rem[3:0];
            end else begin
                go_pad = 1'b1;
            end
        end
        cnt_d = cnt_q;
        if (take_frame || pad_word) begin
            cnt_d = cnt_base + 16'd8;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign fin      = take_frame && in_eof;
    assign fin_n    = n_in;
    assign go_pad   = 1'b0;
    assign pad_word = 1'b0;
`endif

    assign crc_base  = (state_q != PAD && in_sof) ? CRC_INIT : crc_q;
    assign crc_dat   = (state_q == PAD) ? 64'd0 : in_dat_m;
    assign crc_nb    = fin ? fin_n[2:0] : 3'd0;
    assign fcs       = ~crc_nxt;
    // 12-byte view of data followed by FCS; the upper 8 bytes go out now, the lower 4 feed the tail word.
    assign ext       = {crc_dat, 32'd0} | ({fcs, 64'd0} >> {fin_n, 3'b000});
    assign fin_small = (fin_n <= 4'd4);

    crc32_d64_next u_crc (
        .crc_i   (crc_base),
        .data_i  (crc_dat),
        .bytes_i (crc_nb),
        .crc_o   (crc_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DATA: begin
                if (take_frame) begin
                    if (fin) begin
                        state_d = fin_small ? IDLE : TAIL;
                    end else if (go_pad) begin
                        state_d = PAD;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            TAIL: begin
                if (load) begin
                    state_d = IDLE;
                end
            end
            PAD: begin
                if (fin) begin
                    state_d = fin_small ? IDLE : TAIL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        crc_d         = crc_q;
        spill_d       = spill_q;
        spill_bytes_d = spill_bytes_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_sof_d     = out_sof_q;
        out_eof_d     = out_eof_q;
        out_bytes_d   = out_bytes_q;
        err_d         = drop_word || (accept && in_sof && state_q == DATA);
        if (load) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            out_bytes_d = 3'd0;
            if (state_q == TAIL) begin
                out_valid_d = 1'b1;
                out_data_d  = {spill_q, 32'd0};
                out_eof_d   = 1'b1;
                out_bytes_d = spill_bytes_q;
            end else if (take_frame || pad_word || fin) begin
                out_valid_d = 1'b1;
                out_sof_d   = take_frame && in_sof;
                out_data_d  = fin ? ext[95:32] : crc_dat;
                crc_d       = crc_nxt;
                if (fin && fin_small) begin
                    out_eof_d   = 1'b1;
                    out_bytes_d = fin_n[2:0] + 3'd4;
                end else if (fin) begin
                    spill_d       = ext[31:0];
                    spill_bytes_d = fin_n[2:0] - 3'd4;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_q         <= CRC_INIT;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_sof_q     <= 1'b0;
            out_eof_q     <= 1'b0;
            out_bytes_q   <= 3'd0;
            err_q         <= 1'b0;
            spill_q       <= '0;
            spill_bytes_q <= 3'd0;
        end else begin
            crc_q         <= crc_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_sof_q     <= out_sof_d;
            out_eof_q     <= out_eof_d;
            out_bytes_q   <= out_bytes_d;
            err_q         <= err_d;
            spill_q       <= spill_d;
            spill_bytes_q <= spill_bytes_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eof   = out_eof_q;
    assign out_bytes = out_bytes_q;
    assign err_seq   = err_q;

endmodule

// File: tb/tb_tx_crc_append.sv
// Scoreboard bench for tx_crc_append: byte-level frame model predicts output words; a monitor checks words and RX residue.
`timescale 1ns/1ps
module tb_tx_crc_append;

    localparam int          MIN_FRAME_BYTES = 60;
    localparam logic [31:0] POLY            = 32'h04C11DB7;
    localparam logic [31:0] RESIDUE         = 32'hC704DD7B;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [63:0] dat;
        logic        sof;
        logic        eof;
        logic [2:0]  nb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        in_valid, in_sof, in_eof, in_ready;
    logic [2:0]  in_bytes;
    logic [63:0] out_data;
    logic        out_valid, out_sof, out_eof, out_ready, err_seq;
    logic [2:0]  out_bytes;

    int   checks  = 0;
    int   errors  = 0;
    int   err_cnt = 0;
    int   bp_mode = 0;
    exp_t exp_q[$];
    bq_t  rx_q;
    exp_t mon_e;
    logic [31:0] mon_r;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_dat = '0;

    always #5 clk = ~clk;

    tx_crc_append #(.MIN_FRAME_BYTES(MIN_FRAME_BYTES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eof    (in_eof),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .out_eof   (out_eof),
        .out_bytes (out_bytes),
        .out_ready (out_ready),
        .err_seq   (err_seq)
    );

    // Textbook byte-at-a-time CRC-32, MSB first, no reflection.
    function automatic logic [31:0] crc_of(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {b[i], 24'd0};
            for (int k = 0; k < 8; k++) c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Output frame = payload (+ zero pad) + 4 FCS bytes, chopped into 8-byte words.
    task automatic expect_frame(input bq_t p);
        bq_t         s;
        logic [31:0] fcs;
        int          nw;
        exp_t        e;
        s = p;
`ifdef TX_CRC_PAD_EN
        while (s.size() < MIN_FRAME_BYTES) s.push_back(8'd0);
`endif
        fcs = ~crc_of(s);
        for (int i = 3; i >= 0; i--) s.push_back(fcs[8*i +: 8]);
        nw = (s.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            e.dat = '0;
            for (int l = 0; l < 8; l++) if (8*w + l < s.size()) e.dat[63-8*l -: 8] = s[8*w+l];
            e.sof = (w == 0);
            e.eof = (w == nw - 1);
            e.nb  = e.eof ? 3'(s.size() % 8) : 3'd0;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic sof, input logic eof, input logic [2:0] nb);
        int t;
        in_data  = d;
        in_sof   = sof;
        in_eof   = eof;
        in_bytes = nb;
        in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 2000);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        in_sof   = 1'($urandom);
        in_eof   = 1'($urandom);
        in_bytes = 3'($urandom);
    endtask

    // Unused lanes of the eof word and in_bytes of non-eof words carry garbage on purpose.
    task automatic send_frame(input bq_t p, input bit gaps);
        int          nw;
        logic [63:0] d;
        logic [2:0]  nb;
        nw = (p.size() + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            d  = {$urandom, $urandom};
            nb = 3'($urandom);
            for (int l = 0; l < 8; l++) if (8*w + l < p.size()) d[63-8*l -: 8] = p[8*w+l];
            if (w == nw - 1) nb = 3'(p.size() % 8);
            send_word(d, w == 0, w == nw - 1, nb);
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic rand_frame(input int len, output bq_t f);
        f = {};
        for (int i = 0; i < len; i++) f.push_back(8'($urandom));
    endtask

    task automatic run_frame(input bq_t f, input bit gaps);
        expect_frame(f);
        send_frame(f, gaps);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Monitor: scoreboard pop, hold-while-stalled check, RX residue per frame, err_seq pulse count.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (err_seq) err_cnt++;
                if (prev_stall) begin
                    checks++;
                    if (!out_valid || out_data !== prev_dat) begin
                        errors++;
                        $display("FAIL hold got=%0b/%h want=1/%h", out_valid, out_data, prev_dat);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_dat   = out_data;
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word got=%h want=none", out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (out_data !== mon_e.dat || out_sof !== mon_e.sof || out_eof !== mon_e.eof ||
                            (mon_e.eof && out_bytes !== mon_e.nb)) begin
                            errors++;
                            $display("FAIL word got=%h sof=%0b eof=%0b bytes=%0d want=%h sof=%0b eof=%0b bytes=%0d",
                                     out_data, out_sof, out_eof, out_bytes, mon_e.dat, mon_e.sof, mon_e.eof, mon_e.nb);
                        end
                    end
                    if (out_sof) rx_q = {};
                    for (int l = 0; l < 8; l++) begin
                        if (!out_eof || (out_bytes == 3'd0) || (l < int'(out_bytes))) rx_q.push_back(out_data[63-8*l -: 8]);
                    end
                    if (out_eof) begin
                        mon_r = crc_of(rx_q);
                        chk("residue", 64'(mon_r), 64'(RESIDUE));
                        rx_q = {};
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         f;
        logic [63:0] d;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
        in_eof   = 1'b0;
        in_bytes = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_eof", 64'(out_eof), 64'd0);
        chk("reset_out_data", out_data, 64'd0);
        chk("reset_err_seq", 64'(err_seq), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // "123456789": FCS lands in lanes 1..4 of the second word.
        f = {};
        for (int i = 0; i < 9; i++) f.push_back(8'(8'h31 + i));
`ifdef TX_CRC_PAD_EN
        expect_frame(f);
`else
        exp_q.push_back('{dat: 64'h3132333435363738, sof: 1'b1, eof: 1'b0, nb: 3'd0});
        exp_q.push_back('{dat: 64'h39FC891918000000, sof: 1'b0, eof: 1'b1, nb: 3'd5});
`endif
        send_frame(f, 1'b0);
        drain();

        // Full single word: whole FCS spills into a tail word, input blocked meanwhile.
        f = {};
        for (int i = 0; i < 8; i++) f.push_back(8'(8'h31 + i));
        expect_frame(f);
        send_frame(f, 1'b0);
        @(negedge clk);
        chk("tail_in_ready", 64'(in_ready), 64'd0);
        drain();

        // Non-sof word in IDLE is dropped; sof mid-frame abandons the frame.
        send_word({$urandom, $urandom}, 1'b0, 1'b1, 3'd3);
        repeat (2) @(posedge clk);
        #1;
        chk("err_idle_nosof", 64'(err_cnt), 64'd1);
        for (int w = 0; w < 2; w++) begin
            d = {$urandom, $urandom};
            exp_q.push_back('{dat: d, sof: (w == 0), eof: 1'b0, nb: 3'd0});
            send_word(d, w == 0, 1'b0, 3'($urandom));
        end
        rand_frame(20, f);
        run_frame(f, 1'b0);
        drain();
        chk("err_data_sof", 64'(err_cnt), 64'd2);

        // Reset while a frame is in flight and the output is stalled.
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_word({$urandom, $urandom}, 1'b1, 1'b0, 3'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        rand_frame(13, f);
        run_frame(f, 1'b0);
        drain();

        // 14-byte frame: padded to 64 bytes when padding is built in.
        rand_frame(14, f);
        run_frame(f, 1'b0);
        drain();

        for (int i = 0; i < 20; i++) begin
            rand_frame((i < 16) ? i + 1 : $urandom_range(1, 1518), f);
            run_frame(f, 1'b1);
        end
        drain();

        bp_mode = 1;
        for (int i = 0; i < 200; i++) begin
            rand_frame((i < 16) ? i + 1 : $urandom_range(1, 200), f);
            run_frame(f, 1'b1);
        end
        drain();
        bp_mode = 0;
        repeat (4) @(posedge clk);
        #1;

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("err_total", 64'(err_cnt), 64'd2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
